// File: rtl/cmp_result_monitor.sv
`default_nettype none
// ============================================================================
// Module   : cmp_result_monitor
// Purpose  : Statistics and run-length alarm for a one-hot magnitude
//            comparator result {a>b, a<b, a==b}.
// Revision : 1.0 - initial release
// ============================================================================
module cmp_result_monitor #(
    parameter int CNT_W  = 8,
    parameter int RUN_TH = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    input  logic [2:0]       iCmp,
    input  logic             iClear,
    output logic [CNT_W-1:0] oGtCnt,
    output logic [CNT_W-1:0] oLtCnt,
    output logic [CNT_W-1:0] oEqCnt,
    output logic [CNT_W-1:0] oErrCnt,
    output logic [2:0]       oLast,
    output logic [CNT_W-1:0] oRunLen,
    output logic             oRunHit
);

    localparam logic [CNT_W-1:0] c_runTh = CNT_W'(RUN_TH);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        LOCK  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_gtCnt;
    logic [CNT_W-1:0] r_ltCnt;
    logic [CNT_W-1:0] r_eqCnt;
    logic [CNT_W-1:0] r_errCnt;
    logic [CNT_W-1:0] r_runLen;
    logic [2:0]       r_last;
    logic             r_runHit;
    logic             w_legal;
    logic             w_same;
    logic [CNT_W-1:0] w_newRunLen;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_comb begin
        w_legal     = (iCmp == 3'b100) || (iCmp == 3'b010) || (iCmp == 3'b001);
        // oLast is only meaningful outside IDLE, so a match in IDLE is a new run
        w_same      = (r_state != IDLE) && (iCmp == r_last);
        w_newRunLen = w_same ? satInc(r_runLen) : c_one;
        w_nextState = r_state;
        if (iClear) begin
            w_nextState = IDLE;
        end else if (iValid && w_legal) begin
            w_nextState = (w_newRunLen >= c_runTh) ? LOCK : TRACK;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst || iClear) begin
            r_gtCnt  <= '0;
            r_ltCnt  <= '0;
            r_eqCnt  <= '0;
            r_errCnt <= '0;
            r_runLen <= '0;
            r_last   <= 3'b000;
            r_runHit <= 1'b0;
        end else if (iValid) begin
            if (w_legal) begin
                r_last   <= iCmp;
                r_runLen <= w_newRunLen;
                r_runHit <= (w_nextState == LOCK);
                unique case (iCmp)
                    3'b100:  r_gtCnt <= satInc(r_gtCnt);
                    3'b010:  r_ltCnt <= satInc(r_ltCnt);
                    default: r_eqCnt <= satInc(r_eqCnt);
                endcase
            end else begin
                // Illegal codes are tallied but leave run tracking untouched
                r_errCnt <= satInc(r_errCnt);
            end
        end
    end

    assign oGtCnt  = r_gtCnt;
    assign oLtCnt  = r_ltCnt;
    assign oEqCnt  = r_eqCnt;
    assign oErrCnt = r_errCnt;
    assign oLast   = r_last;
    assign oRunLen = r_runLen;
    assign oRunHit = r_runHit;

endmodule
`default_nettype wire

// File: tb/tb_cmp_result_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmp_result_monitor
// Purpose  : Randomised and directed checking of cmp_result_monitor against
//            a behavioural model; two instances cover RUN_TH=4 and RUN_TH=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmp_result_monitor;

    localparam int c_wA  = 4;
    localparam int c_thA = 4;
    localparam int c_wB  = 8;
    localparam int c_thB = 1;

    logic            iClk;
    logic            iRst;
    logic            iValid;
    logic [2:0]      iCmp;
    logic            iClear;

    logic [c_wA-1:0] aGt, aLt, aEq, aErr, aRun;
    logic [2:0]      aLast;
    logic            aHit;
    logic [c_wB-1:0] bGt, bLt, bEq, bErr, bRun;
    logic [2:0]      bLast;
    logic            bHit;

    int checks = 0;
    int errors = 0;

    // Model state, index 0 = instance A, 1 = instance B
    int mGt[2], mLt[2], mEq[2], mErr[2], mRun[2], mLast[2];
    int mMax[2];
    int mTh[2];

    cmp_result_monitor #(.CNT_W(c_wA), .RUN_TH(c_thA)) dutA (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .iCmp(iCmp), .iClear(iClear),
        .oGtCnt(aGt), .oLtCnt(aLt), .oEqCnt(aEq), .oErrCnt(aErr),
        .oLast(aLast), .oRunLen(aRun), .oRunHit(aHit)
    );

    cmp_result_monitor #(.CNT_W(c_wB), .RUN_TH(c_thB)) dutB (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .iCmp(iCmp), .iClear(iClear),
        .oGtCnt(bGt), .oLtCnt(bLt), .oEqCnt(bEq), .oErrCnt(bErr),
        .oLast(bLast), .oRunLen(bRun), .oRunHit(bHit)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic checkVal(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int satAdd(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic modelUpdate(input logic r, input logic cl, input logic v, input logic [2:0] c);
        for (int k = 0; k < 2; k++) begin
            if (r || cl) begin
                mGt[k] = 0; mLt[k] = 0; mEq[k] = 0; mErr[k] = 0; mRun[k] = 0; mLast[k] = 0;
            end else if (v) begin
                if (c == 3'b100 || c == 3'b010 || c == 3'b001) begin
                    if (mLast[k] == int'(c)) mRun[k] = satAdd(mRun[k], mMax[k]);
                    else begin
                        mLast[k] = int'(c);
                        mRun[k]  = 1;
                    end
                    if (c == 3'b100) mGt[k] = satAdd(mGt[k], mMax[k]);
                    if (c == 3'b010) mLt[k] = satAdd(mLt[k], mMax[k]);
                    if (c == 3'b001) mEq[k] = satAdd(mEq[k], mMax[k]);
                end else begin
                    mErr[k] = satAdd(mErr[k], mMax[k]);
                end
            end
        end
    endtask

    task automatic compareAll();
        checkVal("A.gt",   int'(aGt),   mGt[0]);
        checkVal("A.lt",   int'(aLt),   mLt[0]);
        checkVal("A.eq",   int'(aEq),   mEq[0]);
        checkVal("A.err",  int'(aErr),  mErr[0]);
        checkVal("A.last", int'(aLast), mLast[0]);
        checkVal("A.run",  int'(aRun),  mRun[0]);
        checkVal("A.hit",  int'(aHit),  (mRun[0] >= mTh[0]) ? 1 : 0);
        checkVal("B.gt",   int'(bGt),   mGt[1]);
        checkVal("B.lt",   int'(bLt),   mLt[1]);
        checkVal("B.eq",   int'(bEq),   mEq[1]);
        checkVal("B.err",  int'(bErr),  mErr[1]);
        checkVal("B.last", int'(bLast), mLast[1]);
        checkVal("B.run",  int'(bRun),  mRun[1]);
        checkVal("B.hit",  int'(bHit),  (mRun[1] >= mTh[1]) ? 1 : 0);
    endtask

    // Drive one cycle, advance the model on the same edge, check #1 later
    task automatic step(input logic v, input logic [2:0] c, input logic cl, input logic r);
        iValid = v; iCmp = c; iClear = cl; iRst = r;
        @(posedge iClk);
        modelUpdate(r, cl, v, c);
        #1;
        compareAll();
    endtask

    logic [2:0] prevCode;
    logic [2:0] code;

    initial begin
        mMax[0] = (1 << c_wA) - 1; mTh[0] = c_thA;
        mMax[1] = (1 << c_wB) - 1; mTh[1] = c_thB;
        for (int k = 0; k < 2; k++) begin
            mGt[k] = 0; mLt[k] = 0; mEq[k] = 0; mErr[k] = 0; mRun[k] = 0; mLast[k] = 0;
        end
        iRst = 1'b1; iValid = 1'b0; iCmp = 3'b000; iClear = 1'b0;

        step(1'b0, 3'b000, 1'b0, 1'b1);
        step(1'b0, 3'b000, 1'b0, 1'b1);
        repeat (3) step(1'b0, 3'b000, 1'b0, 1'b0);

        // Mixed outcomes
        step(1'b1, 3'b100, 1'b0, 1'b0);
        step(1'b1, 3'b100, 1'b0, 1'b0);
        step(1'b1, 3'b010, 1'b0, 1'b0);
        step(1'b1, 3'b001, 1'b0, 1'b0);
        step(1'b1, 3'b001, 1'b0, 1'b0);
        checkVal("mix.gt",  int'(aGt), 2);
        checkVal("mix.run", int'(aRun), 2);
        checkVal("mix.hit", int'(aHit), 0);

        // Run of four with an idle gap, then a break
        step(1'b0, 3'b000, 1'b1, 1'b0);
        step(1'b1, 3'b010, 1'b0, 1'b0);
        step(1'b1, 3'b010, 1'b0, 1'b0);
        step(1'b0, 3'b010, 1'b0, 1'b0);
        step(1'b0, 3'b100, 1'b0, 1'b0);
        step(1'b1, 3'b010, 1'b0, 1'b0);
        checkVal("run3.hit", int'(aHit), 0);
        step(1'b1, 3'b010, 1'b0, 1'b0);
        checkVal("run4.hit", int'(aHit), 1);
        checkVal("run4.len", int'(aRun), 4);
        step(1'b1, 3'b100, 1'b0, 1'b0);
        checkVal("brk.hit", int'(aHit), 0);

        // Illegal codes inside a run
        step(1'b0, 3'b000, 1'b1, 1'b0);
        step(1'b1, 3'b001, 1'b0, 1'b0);
        step(1'b1, 3'b011, 1'b0, 1'b0);
        step(1'b1, 3'b001, 1'b0, 1'b0);
        step(1'b1, 3'b000, 1'b0, 1'b0);
        step(1'b1, 3'b111, 1'b0, 1'b0);
        step(1'b1, 3'b001, 1'b0, 1'b0);
        checkVal("ill.err", int'(aErr), 3);
        checkVal("ill.run", int'(aRun), 3);

        // Saturation on the 4-bit instance, then clear with a sample
        repeat (20) step(1'b1, 3'b100, 1'b0, 1'b0);
        checkVal("sat.gt",  int'(aGt), 15);
        checkVal("sat.run", int'(aRun), 15);
        checkVal("sat.hit", int'(aHit), 1);
        step(1'b1, 3'b100, 1'b1, 1'b0);
        checkVal("clr.gt", int'(aGt), 0);

        // Reset while locked with a valid sample
        repeat (5) step(1'b1, 3'b001, 1'b0, 1'b0);
        step(1'b1, 3'b001, 1'b0, 1'b1);
        step(1'b1, 3'b001, 1'b0, 1'b0);
        checkVal("rst.run", int'(aRun), 1);

        // Random traffic biased toward repeated codes to build runs
        prevCode = 3'b100;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 65) code = prevCode;
            else if ($urandom_range(0, 99) < 80) begin
                case ($urandom_range(0, 2))
                    0:       code = 3'b100;
                    1:       code = 3'b010;
                    default: code = 3'b001;
                endcase
            end else code = 3'($urandom_range(0, 7));
            prevCode = code;
            step($urandom_range(0, 99) < 75, code,
                 $urandom_range(0, 199) == 0, $urandom_range(0, 399) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmp_result_monitor.md
Name: cmp_result_monitor

Overview:
- Sits directly downstream of the 8-bit magnitude comparator and consumes its 3-bit one-hot result {a>b, a<b, a==b}.
- Keeps saturating per-outcome counters, tracks the run length of consecutive identical results, raises a run alarm at a programmable threshold, and counts illegal (non-one-hot) codes.
- Output drives LEDs / seven-segment display logic on the lab board.

Parameters:
- CNT_W, 8, width of every counter and of the run-length output.
- RUN_TH, 4, run length (1 .. 2^CNT_W-1) at which oRunHit asserts.

Ports:
- iClk  input  1  system clock; all state changes on the rising edge.
- iRst  input  1  synchronous active-high reset.
- iValid  input  1  iCmp holds a sample this cycle.
- iCmp  input  3  comparator result: bit2 = a>b, bit1 = a<b, bit0 = a==b.
- iClear  input  1  synchronous statistics clear.
- oGtCnt  output  CNT_W  count of accepted 3'b100 samples.
- oLtCnt  output  CNT_W  count of accepted 3'b010 samples.
- oEqCnt  output  CNT_W  count of accepted 3'b001 samples.
- oErrCnt  output  CNT_W  count of valid samples with an illegal code.
- oLast  output  3  last legal code accepted; 3'b000 when none.
- oRunLen  output  CNT_W  consecutive identical legal samples ending with oLast.
- oRunHit  output  1  run alarm, high while in LOCK.

Behaviour:
- All outputs are registered. Each accepted sample is visible on outputs the cycle after the edge that samples it (latency 1).
- Priority: iRst > iClear > iValid.
- Reset state:
  - All counters, oRunLen, and oLast are 0.
  - oRunHit is 0.
  - State is IDLE.
- iClear: same effect as reset, in one cycle.
  - A sample presented with iClear in the same cycle is dropped.
- Cycles with iValid=0 change nothing. Runs are not broken by idle cycles.
- Legal codes: 3'b100, 3'b010, 3'b001 only.
  - Any other code with iValid=1 increments oErrCnt.
  - It leaves the other counters, oLast, oRunLen, and state untouched. It does not break a run.
- Counters saturate at 2^CNT_W-1 and never wrap. oRunLen saturates identically.
- FSM states: IDLE, TRACK, LOCK.
  - IDLE, legal sample:
    - oLast = code, oRunLen = 1, matching counter +1.
    - Next state is LOCK if RUN_TH==1, else TRACK.
  - TRACK or LOCK, legal sample equal to oLast:
    - oRunLen +1 (saturating), matching counter +1.
    - Enter or stay in LOCK when the new oRunLen >= RUN_TH.
  - TRACK or LOCK, legal sample different from oLast:
    - oLast = code, oRunLen = 1, matching counter +1.
    - Next state is TRACK, or LOCK if RUN_TH==1.
  - oRunHit = (state == LOCK). It rises in the same cycle that oRunLen first shows RUN_TH.
- Reset or clear mid-run returns to IDLE immediately. The next legal sample starts a new run at 1.
- Saturated oRunLen keeps the state in LOCK.

Test Plan:
- Reset, then 3 idle cycles -> all counters 0, oLast=000, oRunLen=0, oRunHit=0.
- Valid 100,100,010,001,001 on consecutive cycles -> oGtCnt=2, oLtCnt=1, oEqCnt=2, oLast=001, oRunLen=2, oRunHit=0. Each update appears 1 cycle after its sample.
- RUN_TH=4: valid 010 ×4, with idle gaps between samples 2 and 3.
  - oRunHit rises exactly when oRunLen becomes 4.
  - A following 100 drops oRunHit and sets oRunLen=1.
- Valid 011, 000, 111 inside a run of 001 ×3 -> oErrCnt=3, oEqCnt=3, oRunLen=3, oLast unchanged.
- CNT_W=4: 20 valid 100 -> oGtCnt=15, oRunLen=15, oRunHit stays 1. Then iClear together with valid 100 -> all 0, IDLE, sample dropped.
- Assert iRst while in LOCK with iValid=1 -> next cycle all outputs 0. The following 001 gives oRunLen=1, oEqCnt=1.
